writeback: RTL and testbench

- Writeback stage at the tail of the AsyncARM pipeline; it is the consumer end of the alu output interface.
- Pulls one result at a time from alu using the toggle-trigger / level-ready protocol. Writes up to two GPRs into regbank through a two-phase toggle write port, and optionally updates CPSR.
- Replaces the bench process that currently toggles the alu trigger by hand. Brings the regbank write side (triggerInw/dataIn/addrw/cpsrIn) into use.

---
 rtl/asyncarm_pkg.sv | 22 ++
 rtl/wb_toggle_port.sv | 48 ++++
 rtl/writeback.sv | 210 +++++++++++++++++++++
 tb/tb_writeback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/asyncarm_pkg.sv
// Shared AsyncARM definitions: writeback FSM encoding, srcDst field positions
// and default datapath widths.
package asyncarm_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        WB_IDLE    = 3'd0,
        WB_WR1     = 3'd1,
        WB_WR2     = 3'd2,
        WB_CPSR    = 3'd3,
        WB_RELEASE = 3'd4,
        WB_REARM   = 3'd5
    } wb_state_e;

    localparam int SD_PRI_LSB   = 0;
    localparam int SD_SEC_LSB   = 4;
    localparam int SD_SEC_VALID = 8;
    localparam int SD_CPSR      = 9;

endpackage

// File: rtl/wb_toggle_port.sv
// Regbank two-phase write port: request phase, ack compare and ack-wait
// timeout counter.
module wb_toggle_port #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic issue_i,
    input  logic wait_i,
    input  logic ack_i,
    output logic trig_o,
    output logic done_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic             trig_q, trig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match;

    assign match     = (ack_i == trig_q);
    // The timeout edge is the one on which the counter would reach ACK_TIMEOUT.
    assign timeout_o = wait_i && !match && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign done_o    = wait_i && (match || timeout_o);
    assign trig_o    = trig_q;

    always_comb begin
        trig_d = trig_q ^ issue_i;
        cnt_d  = cnt_q;
        if (done_o) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            trig_q <= trig_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/writeback.sv
// AsyncARM writeback stage: consumes alu results and writes GPRs/CPSR.
// Define WB_FORWARD_EN to add the fwdValid/fwdAddr/fwdData forwarding outputs.
module writeback
    import asyncarm_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] cpsrIn,
    input  logic              w,
    input  logic [DATA_W-1:0] srcDstIn,
    input  logic              readyIn,
    output logic              triggerOut,
    output logic [ADDR_W-1:0] addrRB,
    output logic [DATA_W-1:0] dataRB,
    output logic              triggerOutRB,
    input  logic              ackInRB,
    output logic [DATA_W-1:0] cpsrOut,
    output logic              cpsrWe,
    output logic              busy,
    output logic              errOut
`ifdef WB_FORWARD_EN
    ,
    output logic              fwdValid,
    output logic [ADDR_W-1:0] fwdAddr,
    output logic [DATA_W-1:0] fwdData
`endif
);

    wb_state_e         state_q, state_d;
    logic              trig_out_q, trig_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] cpsr_out_q, cpsr_out_d;
    logic              cpsr_we_q, cpsr_we_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] d2_q, d2_d;
    logic [DATA_W-1:0] cpsr_in_q, cpsr_in_d;
    logic [ADDR_W-1:0] sec_addr_q, sec_addr_d;
    logic              sec_valid_q, sec_valid_d;
    logic              cpsr_upd_q, cpsr_upd_d;

    logic rb_issue, rb_wait, rb_done, rb_timeout;
    logic unused_sd;

    assign unused_sd = ^srcDstIn[DATA_W-1:SD_CPSR+1];
    assign rb_wait   = (state_q == WB_WR1) || (state_q == WB_WR2);

    wb_toggle_port #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_port (
        .clk       (clk),
        .reset     (reset),
        .issue_i   (rb_issue),
        .wait_i    (rb_wait),
        .ack_i     (ackInRB),
        .trig_o    (triggerOutRB),
        .done_o    (rb_done),
        .timeout_o (rb_timeout)
    );

    always_comb begin
        state_d     = state_q;
        trig_out_d  = trig_out_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cpsr_out_d  = cpsr_out_q;
        cpsr_we_d   = 1'b0;
        err_d       = err_q | rb_timeout;
        d2_d        = d2_q;
        cpsr_in_d   = cpsr_in_q;
        sec_addr_d  = sec_addr_q;
        sec_valid_d = sec_valid_q;
        cpsr_upd_d  = cpsr_upd_q;
        rb_issue    = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (readyIn) begin
                    d2_d        = dataIn2;
                    cpsr_in_d   = cpsrIn;
                    sec_addr_d  = srcDstIn[SD_SEC_LSB +: ADDR_W];
                    sec_valid_d = w & srcDstIn[SD_SEC_VALID];
                    cpsr_upd_d  = srcDstIn[SD_CPSR];
                    if (w) begin
                        rb_issue = 1'b1;
                        addr_d   = srcDstIn[SD_PRI_LSB +: ADDR_W];
                        data_d   = dataIn1;
                        state_d  = WB_WR1;
                    end else if (srcDstIn[SD_CPSR]) begin
                        cpsr_out_d = cpsrIn;
                        cpsr_we_d  = 1'b1;
                        state_d    = WB_CPSR;
                    end else begin
                        state_d = WB_RELEASE;
                    end
                end
            end
            WB_WR1: begin
                if (rb_done) begin
                    if (sec_valid_q) begin
                        rb_issue = 1'b1;
                        addr_d   = sec_addr_q;
                        data_d   = d2_q;
                        state_d  = WB_WR2;
                    end else if (cpsr_upd_q) begin
                        cpsr_out_d = cpsr_in_q;
                        cpsr_we_d  = 1'b1;
                        state_d    = WB_CPSR;
                    end else begin
                        state_d = WB_RELEASE;
                    end
                end
            end
            WB_WR2: begin
                if (rb_done) begin
                    if (cpsr_upd_q) begin
                        cpsr_out_d = cpsr_in_q;
                        cpsr_we_d  = 1'b1;
                        state_d    = WB_CPSR;
                    end else begin
                        state_d = WB_RELEASE;
                    end
                end
            end
            WB_CPSR: begin
                state_d = WB_RELEASE;
            end
            WB_RELEASE: begin
                trig_out_d = ~trig_out_q;
                state_d    = WB_REARM;
            end
            WB_REARM: begin
                // A result that stays valid must not be consumed a second time.
                if (!readyIn) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WB_IDLE;
            trig_out_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpsr_out_q  <= '0;
            cpsr_we_q   <= 1'b0;
            err_q       <= 1'b0;
            d2_q        <= '0;
            cpsr_in_q   <= '0;
            sec_addr_q  <= '0;
            sec_valid_q <= 1'b0;
            cpsr_upd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_out_q  <= trig_out_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpsr_out_q  <= cpsr_out_d;
            cpsr_we_q   <= cpsr_we_d;
            err_q       <= err_d;
            d2_q        <= d2_d;
            cpsr_in_q   <= cpsr_in_d;
            sec_addr_q  <= sec_addr_d;
            sec_valid_q <= sec_valid_d;
            cpsr_upd_q  <= cpsr_upd_d;
        end
    end

    assign triggerOut = trig_out_q;
    assign addrRB     = addr_q;
    assign dataRB     = data_q;
    assign cpsrOut    = cpsr_out_q;
    assign cpsrWe     = cpsr_we_q;
    assign busy       = (state_q != WB_IDLE);
    assign errOut     = err_q;

`ifdef WB_FORWARD_EN
    logic              fwd_valid_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (rb_done) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= addr_q;
            fwd_data_q  <= data_q;
        end
    end

    assign fwdValid = fwd_valid_q;
    assign fwdAddr  = fwd_addr_q;
    assign fwdData  = fwd_data_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: driver/reference model pushes timed events,
// a negedge monitor pops and compares them.
module tb_writeback;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] dataIn1 = '0, dataIn2 = '0, cpsrIn = '0, srcDstIn = '0;
    logic          w = 1'b0, readyIn = 1'b0, ackInRB = 1'b0;
    logic          triggerOut, triggerOutRB, cpsrWe, busy, errOut;
    logic [AW-1:0] addrRB;
    logic [DW-1:0] dataRB, cpsrOut;
`ifdef WB_FORWARD_EN
    logic          fwdValid;
    logic [AW-1:0] fwdAddr;
    logic [DW-1:0] fwdData;
`endif

    writeback #(.DATA_W(DW), .ADDR_W(AW), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .dataIn1(dataIn1), .dataIn2(dataIn2),
        .cpsrIn(cpsrIn), .w(w), .srcDstIn(srcDstIn), .readyIn(readyIn),
        .triggerOut(triggerOut), .addrRB(addrRB), .dataRB(dataRB),
        .triggerOutRB(triggerOutRB), .ackInRB(ackInRB), .cpsrOut(cpsrOut),
        .cpsrWe(cpsrWe), .busy(busy), .errOut(errOut)
`ifdef WB_FORWARD_EN
        , .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 register write issued, 1 CPSR strobe, 2 alu trigger toggle, 3 error raised
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } ev_t;

    ev_t ev_q[$];
    int  dly_q[$];
    bit  stuck = 1'b0;
    int  nchk = 0, npass = 0;

    task automatic chk(string nm, bit ok, string detail);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: %s", nm, detail);
    endtask

    task automatic observe(int kind, logic [31:0] a, logic [31:0] d);
        ev_t e;
        if (ev_q.size() == 0) begin
            chk("unexpected_event", 1'b0,
                $sformatf("got kind=%0d addr=%0h data=%h at cyc %0d, required no event", kind, a, d, cyc));
        end else begin
            e = ev_q.pop_front();
            chk("event", e.kind == kind && e.addr == a && e.data == d && e.at == cyc,
                $sformatf("got kind=%0d addr=%0h data=%h cyc=%0d, required kind=%0d addr=%0h data=%h cyc=%0d",
                          kind, a, d, cyc, e.kind, e.addr, e.data, e.at));
        end
    endtask

    // Monitor
    logic prev_trb = 1'b0, prev_tr = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (triggerOutRB != prev_trb) observe(0, 32'(addrRB), dataRB);
            if (cpsrWe) observe(1, 32'd0, cpsrOut);
            if (triggerOut != prev_tr) observe(2, 32'd0, 32'd0);
            if (errOut && !prev_err) observe(3, 32'd0, 32'd0);
        end
        prev_trb <= triggerOutRB;
        prev_tr  <= triggerOut;
        prev_err <= errOut;
    end

    // Regbank responder: acks each request after the delay the driver queued.
    initial begin : regbank
        int d;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ackInRB = 1'b0;
            end else if (!stuck && triggerOutRB != ackInRB) begin
                d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                repeat (d) begin @(posedge clk); #1; end
                ackInRB = triggerOutRB;
            end
        end
    end

    function automatic bit outs_zero();
        return !triggerOut && !triggerOutRB && !cpsrWe && !busy && !errOut
               && addrRB == '0 && dataRB == '0 && cpsrOut == '0;
    endfunction

    function automatic string outs_str();
        return $sformatf("trig=%b trigRB=%b we=%b busy=%b err=%b addr=%0h data=%h cpsr=%h, required all 0",
                         triggerOut, triggerOutRB, cpsrWe, busy, errOut, addrRB, dataRB, cpsrOut);
    endfunction

    task automatic push_ev(int kind, logic [31:0] a, logic [31:0] d, int at);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.at = at;
        ev_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        if (busy) chk("idle_wait", 1'b0, "busy still 1 after 50 cycles, required 0");
    endtask

    // Present one alu result and predict the complete event timeline from the
    // protocol rules: each write costs its ack wait plus one cycle, CPSR one
    // cycle, and the trigger toggles one cycle after the last step.
    task automatic present(bit wv, logic [31:0] sd, logic [31:0] a, logic [31:0] b,
                           logic [31:0] c, int d1, int d2);
        logic [3:0] pri, sec;
        int t, eff;
        pri = sd[3:0];
        sec = sd[7:4];
        wait_idle();
        w = wv; srcDstIn = sd; dataIn1 = a; dataIn2 = b; cpsrIn = c; readyIn = 1'b1;
        t = cyc + 1;
        if (wv) begin
            push_ev(0, 32'(pri), a, t);
            eff = stuck ? TMO - 1 : d1;
            if (stuck) push_ev(3, 32'd0, 32'd0, t + TMO);
            else dly_q.push_back(d1);
            t += eff + 1;
            if (sd[8]) begin
                push_ev(0, 32'(sec), b, t);
                eff = stuck ? TMO - 1 : d2;
                if (!stuck) dly_q.push_back(d2);
                t += eff + 1;
            end
        end
        if (sd[9]) begin
            push_ev(1, 32'd0, c, t);
            t += 1;
        end
        push_ev(2, 32'd0, 32'd0, t + 1);
    endtask

    task automatic run_txn(bit wv, logic [31:0] sd, logic [31:0] a, logic [31:0] b,
                           logic [31:0] c, int d1, int d2, int hold);
        int n = 0;
        present(wv, sd, a, b, c, d1, d2);
        while (ev_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        if (ev_q.size() != 0) begin
            chk("txn_timeout", 1'b0, $sformatf("%0d events pending after 300 cycles, required 0", ev_q.size()));
            ev_q.delete();
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("rearm_hold", busy == 1'b1, $sformatf("busy=%b during held readyIn, required 1", busy));
        end
        readyIn = 1'b0;
    endtask

    initial begin : driver
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", outs_zero(), outs_str());
        reset = 1'b0;

        run_txn(1'b1, 32'h003, 32'h12345678, 32'h0, 32'h0, 2, 0, 0);
        run_txn(1'b0, 32'h000, $urandom, $urandom, $urandom, 0, 0, 0);
        run_txn(1'b1, 32'h352, 32'hA, 32'hB, 32'h60000000, 1, 3, 0);
        run_txn(1'b0, 32'h300, $urandom, $urandom, 32'h80000000, 0, 0, 0);
        run_txn(1'b1, 32'h1F7, 32'h11, 32'h22, $urandom, 0, 0, 0);
        run_txn(1'b1, 32'h14F, $urandom, $urandom, $urandom, 0, 4, 10);
        run_txn(1'b1, 32'h0A5, $urandom, $urandom, $urandom, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        // Reset while a write is still waiting for its ack.
        stuck = 1'b1;
        present(1'b1, 32'h001, 32'hDEADBEEF, $urandom, $urandom, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_wr1", busy == 1'b1, $sformatf("busy=%b before reset, required 1", busy));
        reset = 1'b1;
        readyIn = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_mid_write", outs_zero(), outs_str());
        chk("write_issued_before_reset", ev_q.size() == 2,
            $sformatf("%0d events pending, required 2 (timeout and toggle abandoned)", ev_q.size()));
        ev_q.delete();
        dly_q.delete();
        stuck = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_txn(1'b1, 32'h3A9, $urandom, $urandom, $urandom, 1, 2, 0);

        // Ack never arrives: write times out, error becomes sticky, FSM releases.
        stuck = 1'b1;
        run_txn(1'b1, 32'h007, 32'hCAFEF00D, $urandom, $urandom, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", errOut == 1'b1, $sformatf("errOut=%b, required 1", errOut));
        chk("idle_after_timeout", busy == 1'b0, $sformatf("busy=%b, required 0", busy));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
